// File: rtl/counter_monitor_pkg.sv
// Shared types and defaults for the counter stream monitor.
package counter_monitor_pkg;

  // Tracking state of the monitor.
  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    SYNC    = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Consecutive-match counter width; bounds LOCK_COUNT to 1..255.
  localparam int MATCH_CNT_W = 8;

  // Default parameter values for counter_monitor.
  localparam int DEF_WIDTH         = 129;
  localparam int DEF_ERR_CNT_WIDTH = 16;
  localparam int DEF_LOCK_COUNT    = 4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones, with synchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Count up on inc until all-ones; clear wins over inc.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_monitor.sv
// Receive-side checker for a free-running up-counter stream.
//
// Handshake: in_valid is a one-way qualifier with no ready; every beat with
// in_valid=1 is consumed in that cycle (unless clear is also high, in which
// case the beat is discarded). Beats with in_valid=0 change no state.
module counter_monitor
  import counter_monitor_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int ERR_CNT_WIDTH = DEF_ERR_CNT_WIDTH,
  parameter int LOCK_COUNT    = DEF_LOCK_COUNT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_count,
  input  logic                     clear,
  output logic                     locked,
  output logic                     error_pulse,
  output logic                     error_sticky,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [WIDTH-1:0]         expected,
  output state_t                   state_dbg
);

  localparam logic [MATCH_CNT_W-1:0] LOCK_TARGET = MATCH_CNT_W'(LOCK_COUNT);

  state_t                 state_q, state_d;
  logic [MATCH_CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [MATCH_CNT_W-1:0] match_cnt_inc;
  logic [WIDTH-1:0]       expected_q, expected_d;
  logic                   pulse_q, pulse_d;
  logic                   sticky_q, sticky_d;
  logic                   err_inc;
  logic                   sample_match;

  assign sample_match  = (in_count == expected_q);
  assign match_cnt_inc = match_cnt_q + MATCH_CNT_W'(1);

  // State and tracking registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ACQUIRE;
      match_cnt_q <= '0;
      expected_q  <= '0;
      pulse_q     <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      expected_q  <= expected_d;
      pulse_q     <= pulse_d;
      sticky_q    <= sticky_d;
    end
  end

  // Next-state logic: clear first, then per-beat tracking; idle cycles hold.
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    expected_d  = expected_q;
    pulse_d     = 1'b0;
    sticky_d    = sticky_q;
    err_inc     = 1'b0;
    if (clear) begin
      state_d     = ACQUIRE;
      match_cnt_d = '0;
      expected_d  = '0;
      sticky_d    = 1'b0;
    end else if (in_valid) begin
      // Every accepted sample becomes the new reference, match or not.
      expected_d = in_count + WIDTH'(1);
      unique case (state_q)
        ACQUIRE: begin
          state_d     = SYNC;
          match_cnt_d = '0;
        end
        SYNC: begin
          if (sample_match) begin
            match_cnt_d = match_cnt_inc;
            if (match_cnt_inc == LOCK_TARGET) begin
              state_d = LOCKED;
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (!sample_match) begin
            pulse_d     = 1'b1;
            sticky_d    = 1'b1;
            err_inc     = 1'b1;
            state_d     = SYNC;
            match_cnt_d = '0;
          end
        end
        default: begin
          state_d     = ACQUIRE;
          match_cnt_d = '0;
        end
      endcase
    end
  end

  sat_counter #(
    .W(ERR_CNT_WIDTH)
  ) u_err_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (clear),
    .inc    (err_inc),
    .count  (err_count)
  );

  assign locked       = (state_q == LOCKED);
  assign error_pulse  = pulse_q;
  assign error_sticky = sticky_q;
  assign expected     = expected_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor: a default-size instance driven from a
// vector table, and a small instance for wrap and saturation sequences.
module tb_counter_monitor;
  import counter_monitor_pkg::*;

  localparam logic [128:0] ONES = '1;

  logic clk;
  logic rst_n;

  // Big instance (WIDTH=129, LOCK_COUNT=4, ERR_CNT_WIDTH=16).
  logic          b_valid, b_clear;
  logic [128:0]  b_count;
  logic          b_locked, b_pulse, b_sticky;
  logic [15:0]   b_err;
  logic [128:0]  b_exp;
  state_t        b_state;

  // Small instance (WIDTH=8, LOCK_COUNT=2, ERR_CNT_WIDTH=2).
  logic          s_valid, s_clear;
  logic [7:0]    s_count;
  logic          s_locked, s_pulse, s_sticky;
  logic [1:0]    s_err;
  logic [7:0]    s_exp;
  state_t        s_state;

  int checks = 0;
  int errors = 0;

  counter_monitor u_big (
    .clk(clk), .reset_n(rst_n), .in_valid(b_valid), .in_count(b_count),
    .clear(b_clear), .locked(b_locked), .error_pulse(b_pulse),
    .error_sticky(b_sticky), .err_count(b_err), .expected(b_exp),
    .state_dbg(b_state)
  );

  counter_monitor #(.WIDTH(8), .ERR_CNT_WIDTH(2), .LOCK_COUNT(2)) u_small (
    .clk(clk), .reset_n(rst_n), .in_valid(s_valid), .in_count(s_count),
    .clear(s_clear), .locked(s_locked), .error_pulse(s_pulse),
    .error_sticky(s_sticky), .err_count(s_err), .expected(s_exp),
    .state_dbg(s_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic         clr;
    logic [128:0] cnt;
    logic [1:0]   st;
    logic         lk;
    logic         pl;
    logic         sk;
    logic [15:0]  ec;
    logic [128:0] ex;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic clr, input logic [128:0] cnt,
                     input logic [1:0] st, input logic lk, input logic pl,
                     input logic sk, input logic [15:0] ec, input logic [128:0] ex);
    vec_t r;
    r.v = v; r.clr = clr; r.cnt = cnt; r.st = st; r.lk = lk;
    r.pl = pl; r.sk = sk; r.ec = ec; r.ex = ex;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input logic [128:0] act, input logic [128:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // One clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic s_beat(input logic [7:0] val);
    s_valid = 1'b1;
    s_count = val;
    step();
    s_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] se;
    logic [7:0] bad;
    int pulses;
    int e_want;

    rst_n = 1'b0;
    b_valid = 1'b0; b_clear = 1'b0; b_count = '0;
    s_valid = 1'b0; s_clear = 1'b0; s_count = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state.
    check("rst_state", b_state, ACQUIRE);
    check("rst_locked", b_locked, 1'b0);
    check("rst_pulse", b_pulse, 1'b0);
    check("rst_sticky", b_sticky, 1'b0);
    check("rst_err", b_err, 16'd0);
    check("rst_expected", b_exp, 129'd0);
    check("rst_s_state", s_state, ACQUIRE);

    // Wrap on the 8-bit instance: 254,255,0,1.
    s_beat(8'd254);
    check("wrap_254_locked", s_locked, 1'b0);
    check("wrap_254_exp", s_exp, 8'd255);
    s_beat(8'd255);
    check("wrap_255_pulse", s_pulse, 1'b0);
    check("wrap_255_exp", s_exp, 8'd0);
    s_beat(8'd0);
    check("wrap_0_pulse", s_pulse, 1'b0);
    check("wrap_0_locked", s_locked, 1'b1);
    check("wrap_0_exp", s_exp, 8'd1);
    s_beat(8'd1);
    check("wrap_1_locked", s_locked, 1'b1);
    check("wrap_1_pulse", s_pulse, 1'b0);
    check("wrap_1_exp", s_exp, 8'd2);

    // Saturation: five errors, relocking after each.
    se = 8'd2;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      bad = se + 8'd50;
      s_beat(bad);
      if (s_pulse === 1'b1) pulses++;
      e_want = (k < 3) ? k + 1 : 3;
      check($sformatf("sat%0d_pulse", k), s_pulse, 1'b1);
      check($sformatf("sat%0d_err", k), s_err, e_want[1:0]);
      check($sformatf("sat%0d_sticky", k), s_sticky, 1'b1);
      check($sformatf("sat%0d_locked", k), s_locked, 1'b0);
      se = bad + 8'd1;
      s_beat(se);
      check($sformatf("sat%0d_pulse_drop", k), s_pulse, 1'b0);
      check($sformatf("sat%0d_sync", k), s_state, SYNC);
      se = se + 8'd1;
      s_beat(se);
      check($sformatf("sat%0d_relock", k), s_locked, 1'b1);
      se = se + 8'd1;
    end
    check("sat_pulse_events", pulses, 5);
    check("sat_err_held", s_err, 2'd3);
    check("sat_sticky_held", s_sticky, 1'b1);

    // Vector table for the default-size instance.
    // Lock on 10..14.
    add(1, 0, 10, SYNC,   0, 0, 0, 0, 11);
    add(1, 0, 11, SYNC,   0, 0, 0, 0, 12);
    add(1, 0, 12, SYNC,   0, 0, 0, 0, 13);
    add(1, 0, 13, SYNC,   0, 0, 0, 0, 14);
    add(1, 0, 14, LOCKED, 1, 0, 0, 0, 15);
    for (int v = 15; v <= 19; v++) add(1, 0, v, LOCKED, 1, 0, 0, 0, v + 1);
    // Jump 20 -> 25, then relock on 26..29.
    add(1, 0, 25, SYNC,   0, 1, 1, 1, 26);
    add(0, 0, 77, SYNC,   0, 0, 1, 1, 26);
    add(1, 0, 26, SYNC,   0, 0, 1, 1, 27);
    add(1, 0, 27, SYNC,   0, 0, 1, 1, 28);
    add(1, 0, 28, SYNC,   0, 0, 1, 1, 29);
    add(1, 0, 29, LOCKED, 1, 0, 1, 1, 30);
    // Back-to-back mismatches: only the first counts.
    add(1, 0, 40, SYNC,   0, 1, 1, 2, 41);
    add(1, 0, 50, SYNC,   0, 0, 1, 2, 51);
    add(1, 0, 51, SYNC,   0, 0, 1, 2, 52);
    add(1, 0, 52, SYNC,   0, 0, 1, 2, 53);
    add(1, 0, 53, SYNC,   0, 0, 1, 2, 54);
    add(1, 0, 54, LOCKED, 1, 0, 1, 2, 55);
    // Clear together with an in-sequence valid beat.
    add(1, 1, 55, ACQUIRE, 0, 0, 0, 0, 0);
    // Gapped valid: 5,6,7 with three idle cycles between, then 8,9.
    add(1, 0, 5, SYNC, 0, 0, 0, 0, 6);
    for (int g = 0; g < 3; g++) add(0, 0, 99, SYNC, 0, 0, 0, 0, 6);
    add(1, 0, 6, SYNC, 0, 0, 0, 0, 7);
    for (int g = 0; g < 3; g++) add(0, 0, 99, SYNC, 0, 0, 0, 0, 7);
    add(1, 0, 7, SYNC, 0, 0, 0, 0, 8);
    for (int g = 0; g < 3; g++) add(0, 0, 99, SYNC, 0, 0, 0, 0, 8);
    add(1, 0, 8, SYNC,   0, 0, 0, 0, 9);
    add(1, 0, 9, LOCKED, 1, 0, 0, 0, 10);
    // Full-width wrap through all-ones.
    add(0, 1, 0, ACQUIRE, 0, 0, 0, 0, 0);
    add(1, 0, ONES - 129'd3, SYNC, 0, 0, 0, 0, ONES - 129'd2);
    add(1, 0, ONES - 129'd2, SYNC, 0, 0, 0, 0, ONES - 129'd1);
    add(1, 0, ONES - 129'd1, SYNC, 0, 0, 0, 0, ONES);
    add(1, 0, ONES,          SYNC, 0, 0, 0, 0, 0);
    add(1, 0, 0, LOCKED, 1, 0, 0, 0, 1);
    add(1, 0, 1, LOCKED, 1, 0, 0, 0, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      b_valid = vecs[i].v;
      b_clear = vecs[i].clr;
      b_count = vecs[i].cnt;
      step();
      check($sformatf("vec%0d_state", i), b_state, vecs[i].st);
      check($sformatf("vec%0d_locked", i), b_locked, vecs[i].lk);
      check($sformatf("vec%0d_pulse", i), b_pulse, vecs[i].pl);
      check($sformatf("vec%0d_sticky", i), b_sticky, vecs[i].sk);
      check($sformatf("vec%0d_err", i), b_err, vecs[i].ec);
      check($sformatf("vec%0d_expected", i), b_exp, vecs[i].ex);
    end
    b_valid = 1'b0;
    b_clear = 1'b0;

    // Asynchronous reset mid-SYNC.
    b_valid = 1'b1; b_count = 129'd7;
    step();
    check("ar_err_pulse", b_pulse, 1'b1);
    check("ar_err_count", b_err, 16'd1);
    b_count = 129'd8;
    step();
    b_valid = 1'b0;
    check("ar_pre_state", b_state, SYNC);
    check("ar_pre_expected", b_exp, 129'd9);
    rst_n = 1'b0;
    #2;
    check("ar_state", b_state, ACQUIRE);
    check("ar_locked", b_locked, 1'b0);
    check("ar_sticky", b_sticky, 1'b0);
    check("ar_err", b_err, 16'd0);
    check("ar_expected", b_exp, 129'd0);
    rst_n = 1'b1;
    b_valid = 1'b1; b_count = 129'd30;
    step();
    b_valid = 1'b0;
    check("ar_reacq_state", b_state, SYNC);
    check("ar_reacq_expected", b_exp, 129'd31);
    check("ar_reacq_locked", b_locked, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
